// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ack channel between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, one-entry fetch buffer, IF/ID enable/flush control.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_BOOT  | first cycle after reset, no request
// S_FETCH | buffer empty, requesting imem at pc
// S_FULL  | buffer holds a valid instruction for IF/ID
// S_DRAIN | stale request outstanding at drain_addr, data discarded
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter logic [31:0] NOP_INST       = 32'h0000_0013,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_d_i,
   input  logic            redirect_i,
   input  logic [31:0]     redirect_pc_i,
   if_fetch_unit_if.master imem,
   output logic [31:0]     if_inst_o,
   output logic [31:0]     if_pc_o,
   output logic [31:0]     if_pc4_o,
   output logic            if_valid_o,
   output logic            ifid_enable_o,
   output logic            ifid_flush_o,
   output logic            fetch_err_o
);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FULL, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_pc4_q, buf_pc4_d;

   logic        consume;
   logic        req;
   logic        load;
   logic [31:0] addr;
   logic [31:0] redirect_tgt;
   logic        unused_bits;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             fetch_err_q, fetch_err_d;
`endif

   assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
   assign if_valid_o   = (state_q == S_FULL);
   assign consume      = if_valid_o & ~stall_d_i & ~redirect_i;
   assign req          = (state_q == S_FETCH) | (state_q == S_DRAIN) |
                         ((state_q == S_FULL) & consume);
   assign addr         = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

   assign imem.req      = req;
   assign imem.addr     = addr;
   assign if_inst_o     = if_valid_o ? buf_inst_q : NOP_INST;
   assign if_pc_o       = buf_pc_q;
   assign if_pc4_o      = buf_pc4_q;
   assign ifid_enable_o = ~stall_d_i | redirect_i;
   assign ifid_flush_o  = redirect_i | ~if_valid_o;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      buf_inst_d   = buf_inst_q;
      buf_pc_d     = buf_pc_q;
      buf_pc4_d    = buf_pc4_q;
      load         = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
      fetch_err_d  = fetch_err_q;
`endif

      unique case (state_q)
         S_BOOT:  state_d = S_FETCH;
         S_FETCH: if (!redirect_i && imem.ack) load = 1'b1;
         S_FULL: begin
            if (consume) begin
               if (imem.ack) load = 1'b1;
               else          state_d = S_FETCH;
            end
         end
         S_DRAIN: if (imem.ack) state_d = S_FETCH;
         default: state_d = S_BOOT;
      endcase

      if (load) begin
         buf_inst_d = imem.rdata;
         buf_pc_d   = pc_q;
         buf_pc4_d  = pc_q + 32'd4;
         pc_d       = pc_q + 32'd4;
         state_d    = S_FULL;
      end

      // An unacked request cannot be cancelled on the bus, so its response is drained.
      if (redirect_i && (state_q != S_BOOT)) begin
         pc_d         = redirect_tgt;
         drain_addr_d = addr;
         state_d      = (req && !imem.ack) ? S_DRAIN : S_FETCH;
      end

`ifdef FETCH_TIMEOUT_EN
      if (redirect_i || (req && imem.ack)) begin
         tmo_cnt_d = '0;
      end else if (req) begin
         if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt_d   = '0;
            fetch_err_d = 1'b1;
            state_d     = S_FETCH;
         end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= S_BOOT;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         buf_inst_q   <= NOP_INST;
         buf_pc_q     <= RESET_PC;
         buf_pc4_q    <= RESET_PC + 32'd4;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         buf_inst_q   <= buf_inst_d;
         buf_pc_q     <= buf_pc_d;
         buf_pc4_q    <= buf_pc4_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         tmo_cnt_q   <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         tmo_cnt_q   <= tmo_cnt_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   assign fetch_err_o = fetch_err_q;
   assign unused_bits = ^redirect_pc_i[1:0];
`else
   assign fetch_err_o = 1'b0;
   assign unused_bits = ^{redirect_pc_i[1:0], TIMEOUT_CYCLES};
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, randomized stream vs. program-order model, watchdog sequence.
module tb_if_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int unsigned TMO    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] rpc = '0;
   logic [31:0] if_inst, if_pc, if_pc4;
   logic        if_valid, ifid_en, ifid_fl, fetch_err;

   int checks = 0;
   int errors = 0;

   if_fetch_unit_if bus ();

   always #5 clk = ~clk;

   if_fetch_unit #(
      .RESET_PC(RST_PC), .NOP_INST(NOP), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i(clk), .rst_i(rst), .stall_d_i(stall), .redirect_i(redir),
      .redirect_pc_i(rpc), .imem(bus.master),
      .if_inst_o(if_inst), .if_pc_o(if_pc), .if_pc4_o(if_pc4),
      .if_valid_o(if_valid), .ifid_enable_o(ifid_en), .ifid_flush_o(ifid_fl),
      .fetch_err_o(fetch_err)
   );

   typedef struct {
      logic        rst, stall, redir;
      logic [31:0] rpc;
      logic        ack;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic        flush, en;
   } vec_t;

   vec_t tbl[34];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
   endfunction

   function automatic vec_t mk(input int r, input int s, input int d, input logic [31:0] p,
                               input int a, input int q, input logic [31:0] ad, input int v,
                               input logic [31:0] pc, input int fl, input int en);
      vec_t t;
      t.rst = (r != 0); t.stall = (s != 0); t.redir = (d != 0); t.rpc = p; t.ack = (a != 0);
      t.req = (q != 0); t.addr = ad; t.valid = (v != 0); t.pc = pc;
      t.flush = (fl != 0); t.en = (en != 0);
      return t;
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; memory answers with the word for the current addr.
   task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] p,
                        input logic a);
      rst       = r;
      stall     = s;
      redir     = d;
      rpc       = p;
      bus.ack   = a;
      bus.rdata = mem_word(bus.addr);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      logic        s, d, a, exp_err;
      logic [31:0] p, exp_pc, prev_addr;
      logic        prev_req, prev_ack;
      int          consumed;

      bus.ack   = 1'b0;
      bus.rdata = '0;

      //             rst stl rd rpc            ack  req addr           v  pc             fl en
      tbl[0]  = mk(1, 0, 0, 0,             1,   0, 0,             0, 0,             1, 1);
      tbl[1]  = mk(1, 0, 0, 0,             1,   1, 0,             0, 0,             1, 1);
      tbl[2]  = mk(1, 0, 0, 0,             1,   1, 'h4,           1, 0,             0, 1);
      tbl[3]  = mk(1, 0, 0, 0,             1,   1, 'h8,           1, 'h4,           0, 1);
      tbl[4]  = mk(1, 0, 0, 0,             1,   1, 'hC,           1, 'h8,           0, 1);
      tbl[5]  = mk(1, 1, 0, 0,             1,   0, 0,             1, 'hC,           0, 0);
      tbl[6]  = mk(1, 1, 0, 0,             1,   0, 0,             1, 'hC,           0, 0);
      tbl[7]  = mk(1, 1, 0, 0,             0,   0, 0,             1, 'hC,           0, 0);
      tbl[8]  = mk(1, 0, 0, 0,             1,   1, 'h10,          1, 'hC,           0, 1);
      tbl[9]  = mk(1, 0, 0, 0,             1,   1, 'h14,          1, 'h10,          0, 1);
      tbl[10] = mk(0, 0, 0, 0,             1,   1, 'h18,          1, 'h14,          0, 1);
      tbl[11] = mk(0, 0, 0, 0,             0,   0, 0,             0, 0,             1, 1);
      tbl[12] = mk(1, 0, 0, 0,             0,   0, 0,             0, 0,             1, 1);
      tbl[13] = mk(1, 0, 0, 0,             0,   1, 0,             0, 0,             1, 1);
      tbl[14] = mk(1, 0, 0, 0,             0,   1, 0,             0, 0,             1, 1);
      tbl[15] = mk(1, 0, 0, 0,             1,   1, 0,             0, 0,             1, 1);
      tbl[16] = mk(1, 0, 0, 0,             0,   1, 'h4,           1, 0,             0, 1);
      tbl[17] = mk(1, 0, 0, 0,             0,   1, 'h4,           0, 0,             1, 1);
      tbl[18] = mk(1, 0, 0, 0,             1,   1, 'h4,           0, 0,             1, 1);
      tbl[19] = mk(1, 0, 0, 0,             0,   1, 'h8,           1, 'h4,           0, 1);
      tbl[20] = mk(1, 1, 1, 'h100,         0,   1, 'h8,           0, 'h4,           1, 1);
      tbl[21] = mk(1, 0, 0, 0,             0,   1, 'h8,           0, 'h4,           1, 1);
      tbl[22] = mk(1, 0, 0, 0,             1,   1, 'h8,           0, 'h4,           1, 1);
      tbl[23] = mk(1, 0, 0, 0,             0,   1, 'h100,         0, 'h4,           1, 1);
      tbl[24] = mk(1, 0, 0, 0,             1,   1, 'h100,         0, 'h4,           1, 1);
      tbl[25] = mk(1, 0, 0, 0,             1,   1, 'h104,         1, 'h100,         0, 1);
      tbl[26] = mk(1, 0, 0, 0,             0,   1, 'h108,         1, 'h104,         0, 1);
      tbl[27] = mk(1, 0, 1, 'h203,         1,   1, 'h108,         0, 'h104,         1, 1);
      tbl[28] = mk(1, 0, 0, 0,             1,   1, 'h200,         0, 'h104,         1, 1);
      tbl[29] = mk(1, 0, 0, 0,             1,   1, 'h204,         1, 'h200,         0, 1);
      tbl[30] = mk(1, 0, 1, 'hFFFF_FFFC,   1,   0, 0,             1, 'h204,         1, 1);
      tbl[31] = mk(1, 0, 0, 0,             1,   1, 'hFFFF_FFFC,   0, 'h204,         1, 1);
      tbl[32] = mk(1, 0, 0, 0,             1,   1, 0,             1, 'hFFFF_FFFC,   0, 1);
      tbl[33] = mk(1, 0, 0, 0,             1,   1, 'h4,           1, 0,             0, 1);

      do_reset();
      for (int i = 0; i < 34; i++) begin
         @(posedge clk);
         #1 drive(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].ack);
         #3;
         chk1($sformatf("tbl%0d_req", i), bus.req, tbl[i].req);
         if (tbl[i].req) chk32($sformatf("tbl%0d_addr", i), bus.addr, tbl[i].addr);
         chk1($sformatf("tbl%0d_valid", i), if_valid, tbl[i].valid);
         chk32($sformatf("tbl%0d_pc", i), if_pc, tbl[i].pc);
         chk32($sformatf("tbl%0d_pc4", i), if_pc4, tbl[i].pc + 32'd4);
         chk32($sformatf("tbl%0d_inst", i), if_inst, tbl[i].valid ? mem_word(tbl[i].pc) : NOP);
         chk1($sformatf("tbl%0d_flush", i), ifid_fl, tbl[i].flush);
         chk1($sformatf("tbl%0d_enable", i), ifid_en, tbl[i].en);
         chk1($sformatf("tbl%0d_err", i), fetch_err, 1'b0);
      end

      // Random traffic: IF/ID must see program order from the last redirect target, with memory data.
      do_reset();
      exp_pc   = RST_PC;
      consumed = 0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_addr = '0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         s = ($urandom_range(0, 9) < 3);
         d = (c > 0) && ($urandom_range(0, 19) == 0);
         a = ($urandom_range(0, 9) < 6);
         p = $urandom;
         #1 drive(1'b1, s, d, p, a);
         #3;
`ifndef FETCH_TIMEOUT_EN
         if (prev_req && !prev_ack) begin
            chk1("rnd_req_hold", bus.req, 1'b1);
            chk32("rnd_addr_hold", bus.addr, prev_addr);
         end
         chk1("rnd_err", fetch_err, 1'b0);
`endif
         chk1("rnd_enable", ifid_en, !s || d);
         chk1("rnd_flush", ifid_fl, d || !if_valid);
         if (!if_valid) chk32("rnd_nop", if_inst, NOP);
         if (if_valid && !s && !d) begin
            chk32("rnd_pc", if_pc, exp_pc);
            chk32("rnd_pc4", if_pc4, exp_pc + 32'd4);
            chk32("rnd_inst", if_inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (d) exp_pc = {p[31:2], 2'b00};
         prev_req  = bus.req;
         prev_ack  = a;
         prev_addr = bus.addr;
      end
      chk1("rnd_progress", consumed > 200, 1'b1);

      // Ack never arrives: request stays on pc 0; watchdog (if built in) flags after TMO cycles.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1 drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
         #3;
         chk1($sformatf("tmo%0d_req", i), bus.req, i != 0);
         if (i != 0) chk32($sformatf("tmo%0d_addr", i), bus.addr, RST_PC);
`ifdef FETCH_TIMEOUT_EN
         exp_err = (i >= int'(TMO) + 1);
`else
         exp_err = 1'b0;
`endif
         chk1($sformatf("tmo%0d_err", i), fetch_err, exp_err);
      end
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #4;
      chk1("tmo_err_cleared", fetch_err, 1'b0);
      chk1("tmo_valid_cleared", if_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
